// File: rtl/counter_modulo_n_sync_pkg.sv
// rtl/counter_modulo_n_sync_pkg.sv - shared types and parameter checks for the modulo-N counter
`include "counter_defines.vh"

package counter_modulo_n_sync_pkg;

    typedef enum logic {
        DIR_DOWN = `COUNT_DOWN,
        DIR_UP   = `COUNT_UP
    } count_dir_e;

    // Legal when 2 <= modulus <= 2**width and the reset value lies inside the count range.
    function automatic bit params_ok(input int modulus, input int width, input int reset_value);
        return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width)) &&
               (reset_value >= 0) && (reset_value < modulus);
    endfunction

endpackage

// File: rtl/counter_defines.vh
// rtl/counter_defines.vh - direction encodings shared by the counter blocks
`ifndef COUNTER_DEFINES_VH
`define COUNTER_DEFINES_VH
`define COUNT_UP   1'b1
`define COUNT_DOWN 1'b0
`endif

// File: rtl/counter_modulo_n_nextstate.sv
// rtl/counter_modulo_n_nextstate.sv - combinational next count, load range check and terminal count
module counter_modulo_n_nextstate
    import counter_modulo_n_sync_pkg::*;
#(
    parameter int MODULUS = 3,
    parameter int WIDTH   = 2
) (
    input  logic [WIDTH-1:0] i_signal_q,
    input  logic             i_up_down,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_next_q,
    output logic             o_range_error,
    output logic             o_terminal_count
);

    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MODULUS - 1);

    logic w_up;
    logic w_at_max;
    logic w_at_zero;
    logic w_out_of_range;

    assign w_up           = (count_dir_e'(i_up_down) == DIR_UP);
    assign w_at_max       = (i_signal_q == L_MAX);
    assign w_at_zero      = (i_signal_q == '0);
    assign w_out_of_range = (i_signal_q > L_MAX);

    always_comb begin
        o_next_q      = i_signal_q;
        o_range_error = 1'b0;
        if (i_load) begin
            if (i_load_value > L_MAX) begin
                o_next_q      = '0;
                o_range_error = 1'b1;
            end else begin
                o_next_q = i_load_value;
            end
        end else if (i_enable) begin
            // A forced illegal state recovers to 0 regardless of direction.
            if (w_out_of_range) begin
                o_next_q = '0;
            end else if (w_up) begin
                o_next_q = w_at_max ? '0 : i_signal_q + 1'b1;
            end else begin
                o_next_q = w_at_zero ? L_MAX : i_signal_q - 1'b1;
            end
        end
    end

    assign o_terminal_count = i_enable & ~i_load &
                              ((w_up & w_at_max) | (~w_up & w_at_zero));

endmodule

// File: rtl/counter_modulo_n_sync.sv
// rtl/counter_modulo_n_sync.sv - falling-edge modulo-N up/down counter with load and cascade flag
module counter_modulo_n_sync
    import counter_modulo_n_sync_pkg::*;
#(
    parameter int MODULUS     = 3,
    parameter int WIDTH       = 2,
    parameter int RESET_VALUE = 0
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] signal_q,
    output logic [WIDTH-1:0] signal_q_,
    output logic             terminal_count,
    output logic             load_error
);

    generate
        if (!params_ok(MODULUS, WIDTH, RESET_VALUE)) begin : g_bad_params
            $error("counter_modulo_n_sync: need 2 <= MODULUS <= 2**WIDTH and RESET_VALUE < MODULUS");
        end
    endgenerate

    localparam logic [WIDTH-1:0] L_RESET = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] r_q;
    logic             r_load_error;
    logic [WIDTH-1:0] w_next_q;
    logic             w_range_error;
    logic             w_terminal_count;

    counter_modulo_n_nextstate #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_nextstate (
        .i_signal_q       (r_q),
        .i_up_down        (up_down),
        .i_enable         (enable),
        .i_load           (load),
        .i_load_value     (load_value),
        .o_next_q         (w_next_q),
        .o_range_error    (w_range_error),
        .o_terminal_count (w_terminal_count)
    );

    always_ff @(negedge clockpulse) begin
        if (clear) begin
            r_q          <= L_RESET;
            r_load_error <= 1'b0;
        end else begin
            r_q          <= w_next_q;
            r_load_error <= w_range_error;
        end
    end

    // Clear wins this edge, so the cascade flag must not let a downstream stage advance.
    assign terminal_count = w_terminal_count & ~clear;
    assign signal_q       = r_q;
    assign signal_q_      = ~r_q;
    assign load_error     = r_load_error;

endmodule

// File: tb/tb_counter_modulo_n_sync.sv
// tb/tb_counter_modulo_n_sync.sv - self-checking bench for counter_modulo_n_sync
module tb_counter_modulo_n_sync;

    logic       clk = 1'b1;
    logic       clr = 1'b1;
    logic       ld  = 1'b0;
    logic       en  = 1'b0;
    logic       ud  = 1'b1;
    logic [3:0] lv  = 4'd0;

    always #5 clk = ~clk;

    logic [1:0] m3_q, m3_qn;
    logic       m3_tc, m3_err;
    logic [3:0] un_q, un_qn, te_q, te_qn, m16_q, m16_qn;
    logic       un_tc, un_err, te_tc, te_err, m16_tc, m16_err;
    logic [2:0] rn_q, rn_qn;
    logic       rn_tc, rn_err;

    counter_modulo_n_sync #(.MODULUS(3), .WIDTH(2), .RESET_VALUE(0)) u_m3 (
        .clockpulse(clk), .clear(clr), .enable(en), .up_down(ud), .load(ld),
        .load_value(lv[1:0]), .signal_q(m3_q), .signal_q_(m3_qn),
        .terminal_count(m3_tc), .load_error(m3_err));

    counter_modulo_n_sync #(.MODULUS(10), .WIDTH(4), .RESET_VALUE(0)) u_units (
        .clockpulse(clk), .clear(clr), .enable(en), .up_down(ud), .load(ld),
        .load_value(lv), .signal_q(un_q), .signal_q_(un_qn),
        .terminal_count(un_tc), .load_error(un_err));

    counter_modulo_n_sync #(.MODULUS(10), .WIDTH(4), .RESET_VALUE(0)) u_tens (
        .clockpulse(clk), .clear(clr), .enable(un_tc), .up_down(ud), .load(1'b0),
        .load_value(4'd0), .signal_q(te_q), .signal_q_(te_qn),
        .terminal_count(te_tc), .load_error(te_err));

    counter_modulo_n_sync #(.MODULUS(16), .WIDTH(4), .RESET_VALUE(0)) u_m16 (
        .clockpulse(clk), .clear(clr), .enable(en), .up_down(ud), .load(ld),
        .load_value(lv), .signal_q(m16_q), .signal_q_(m16_qn),
        .terminal_count(m16_tc), .load_error(m16_err));

    counter_modulo_n_sync #(.MODULUS(6), .WIDTH(3), .RESET_VALUE(2)) u_rnd (
        .clockpulse(clk), .clear(clr), .enable(en), .up_down(ud), .load(ld),
        .load_value(lv[2:0]), .signal_q(rn_q), .signal_q_(rn_qn),
        .terminal_count(rn_tc), .load_error(rn_err));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic u, input logic [3:0] v);
        clr = c; ld = l; en = e; ud = u; lv = v;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       c, l, e, u;
        logic [3:0] v;
        int         exp_q;
        int         exp_tc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int mq, merr, mtc, n, exp_q;
        logic c, l, e, u;
        logic [3:0] v;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 0, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1, 0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 2, 0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 0, 1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1, 0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 2, 0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 0, 1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1, 0};

        // Power-up with clear held.
        drive(1, 0, 1, 1, 4'd0);
        tick();
        chk("reset_m3_q", m3_q, 0);
        chk("reset_m3_qn", m3_qn, 3);
        chk("reset_m3_err", m3_err, 0);
        chk("reset_rnd_q", rn_q, 2);
        chk("reset_rnd_qn", rn_qn, 5);
        chk("reset_m16_q", m16_q, 0);
        chk("reset_tc_clear", un_tc, 0);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].c, tbl[i].l, tbl[i].e, tbl[i].u, tbl[i].v);
            chk($sformatf("m3_tc[%0d]", i), m3_tc, tbl[i].exp_tc);
            tick();
            chk($sformatf("m3_q[%0d]", i), m3_q, tbl[i].exp_q);
            chk($sformatf("m3_qn[%0d]", i), m3_qn, (~tbl[i].exp_q) & 3);
        end

        // Modulo-10 down count from clear, then hold.
        drive(1, 0, 0, 0, 4'd0);
        tick();
        mq = 0;
        for (int i = 0; i < 11; i++) begin
            drive(0, 0, 1, 0, 4'd0);
            chk($sformatf("m10_dn_tc[%0d]", i), un_tc, (mq == 0) ? 1 : 0);
            tick();
            mq = (mq + 9) % 10;
            chk($sformatf("m10_dn_q[%0d]", i), un_q, mq);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 4'd0);
            chk($sformatf("m10_hold_tc[%0d]", i), un_tc, 0);
            tick();
            chk($sformatf("m10_hold_q[%0d]", i), un_q, 9);
        end

        // Loads, in-range and out-of-range.
        drive(0, 1, 0, 1, 4'd7);
        tick();
        chk("m10_load7_q", un_q, 7);
        chk("m10_load7_err", un_err, 0);
        drive(0, 1, 1, 1, 4'd12);
        chk("m10_load_tc", un_tc, 0);
        tick();
        chk("m10_load12_q", un_q, 0);
        chk("m10_load12_err", un_err, 1);
        drive(0, 0, 0, 1, 4'd0);
        tick();
        chk("m10_err_clears", un_err, 0);
        chk("m10_err_hold_q", un_q, 0);

        // Clear beats load and enable; then load beats enable.
        drive(0, 1, 0, 1, 4'd5);
        tick();
        chk("m10_pre5_q", un_q, 5);
        drive(1, 1, 1, 1, 4'd3);
        chk("m10_clr_tc", un_tc, 0);
        tick();
        chk("m10_clr_prio_q", un_q, 0);
        drive(0, 1, 1, 1, 4'd4);
        tick();
        chk("m10_load_prio_q", un_q, 4);

        // Two-stage decade cascade.
        drive(1, 0, 0, 1, 4'd0);
        tick();
        for (n = 1; n <= 25; n++) begin
            drive(0, 0, 1, 1, 4'd0);
            tick();
            chk($sformatf("casc_units[%0d]", n), un_q, n % 10);
            chk($sformatf("casc_tens[%0d]", n), te_q, (n / 10) % 10);
        end

        // Full binary modulus wrap and reversal.
        drive(0, 1, 0, 1, 4'd14);
        tick();
        chk("m16_load14", m16_q, 14);
        exp_q = 14;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 4'd0);
            chk($sformatf("m16_up_tc[%0d]", i), m16_tc, (exp_q == 15) ? 1 : 0);
            tick();
            exp_q = (exp_q + 1) % 16;
            chk($sformatf("m16_up_q[%0d]", i), m16_q, exp_q);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0, 4'd0);
            chk($sformatf("m16_dn_tc[%0d]", i), m16_tc, (exp_q == 0) ? 1 : 0);
            tick();
            exp_q = (exp_q + 15) % 16;
            chk($sformatf("m16_dn_q[%0d]", i), m16_q, exp_q);
        end

        // Randomized traffic on the MODULUS=6, RESET_VALUE=2 instance.
        drive(1, 0, 0, 1, 4'd0);
        tick();
        mq = 2;
        merr = 0;
        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(15) == 0);
            l = ($urandom_range(5) == 0);
            e = 1'($urandom_range(1));
            u = 1'($urandom_range(1));
            v = 4'($urandom_range(7));
            mtc = (e && !l && !c && ((u && mq == 5) || (!u && mq == 0))) ? 1 : 0;
            drive(c, l, e, u, v);
            chk($sformatf("rnd_tc[%0d]", i), rn_tc, mtc);
            tick();
            if (c) begin
                mq = 2;
                merr = 0;
            end else if (l) begin
                if (int'(v) < 6) begin
                    mq = int'(v);
                    merr = 0;
                end else begin
                    mq = 0;
                    merr = 1;
                end
            end else begin
                merr = 0;
                if (e) mq = u ? (mq + 1) % 6 : (mq + 5) % 6;
            end
            chk($sformatf("rnd_q[%0d]", i), rn_q, mq);
            chk($sformatf("rnd_qn[%0d]", i), rn_qn, (~mq) & 7);
            chk($sformatf("rnd_err[%0d]", i), rn_err, merr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_modulo_n_sync.md
Name: counter_modulo_n_sync

Overview:
Parametrised synchronous modulo-N counter: successor to the fixed modulo-3 synchronous counter, generalised in modulus and width. Adds count enable, up/down mode, synchronous parallel load, and a cascade terminal-count output. Serves as the standard lab counter primitive for dividers, sequencers and cascaded decade/modulo chains. Exposes true and complemented state outputs, as the family always has.

Parameters:
MODULUS, 3, count modulus N; legal range 2..2**WIDTH; state sequence is 0..N-1.
WIDTH, 2, state width in bits; must satisfy 2**WIDTH >= MODULUS; elaboration error otherwise.
RESET_VALUE, 0, state after clear; must be < MODULUS; elaboration error otherwise.

Ports:
clockpulse  input  1  counter clock; all state updates on the falling edge.
clear  input  1  synchronous, active-high reset; sampled on the falling edge of clockpulse.
enable  input  1  count enable; 1 = advance one step per clock.
up_down  input  1  direction; 1 = count up, 0 = count down.
load  input  1  synchronous parallel load strobe.
load_value  input  WIDTH  value loaded when load=1.
signal_q  output  WIDTH  current count.
signal_q_  output  WIDTH  bitwise complement of signal_q, always.
terminal_count  output  1  combinational cascade flag (see Behaviour).
load_error  output  1  registered; 1 for one cycle after an out-of-range load.

Behaviour:
- One clock (clockpulse, falling edge); reset is synchronous and active-high (clear); no asynchronous paths.
- Priority on each falling edge: clear > load > enable > hold.
- clear=1: signal_q <= RESET_VALUE; signal_q_ <= ~RESET_VALUE; load_error <= 0. Same values on the first edge after power-up with clear held.
- Clear asserted mid-count overrides load and enable in that cycle; the count resumes from RESET_VALUE on the first edge with clear=0.
- load=1 with load_value < MODULUS: signal_q <= load_value; load_error <= 0.
- load=1 with load_value >= MODULUS: signal_q <= 0; load_error <= 1 for exactly one cycle.
- Load ignores enable and up_down.
- enable=1, up_down=1: signal_q <= (signal_q == MODULUS-1) ? 0 : signal_q+1.
- enable=1, up_down=0: signal_q <= (signal_q == 0) ? MODULUS-1 : signal_q-1.
- enable=0: hold.
- load_error <= 0 on every edge without an out-of-range load.
- Latency: one clock from input sampling to the updated signal_q.
- terminal_count = enable & ~load & ~clear & ((up_down & signal_q==MODULUS-1) | (~up_down & signal_q==0)). It is purely combinational, so a following stage's enable sees it in the same cycle for synchronous cascading.
- Direction change takes effect on the next edge. There is no extra state and no glitch in signal_q.
- Unreachable states (signal_q >= MODULUS) cannot occur after clear. If forced, the next enabled count edge goes to 0 in either direction; terminal_count stays 0 while out of range.
- MODULUS = 2**WIDTH degenerates to plain binary wrap; required to work.
- Arithmetic is unsigned WIDTH-bit; comparisons use WIDTH-bit constants derived from MODULUS.

Decomposition:
- Shared include file counter_defines.vh holds the direction encodings COUNT_UP=1'b1 and COUNT_DOWN=1'b0, reused by other counter blocks.
- One sub-module is natural: counter_modulo_n_nextstate, a combinational block. Inputs: signal_q, up_down, enable, load, load_value. Outputs: next state, range-error flag, terminal_count.
- The top level holds only the WIDTH+1 registers, the clear/priority mux, and the complement output.

Test Plan:
- MODULUS=3, WIDTH=2: clear 1 edge, then enable=1, up_down=1 for 7 edges -> signal_q 0,1,2,0,1,2,0,1; signal_q_ = ~signal_q; terminal_count=1 only while q=2.
- MODULUS=10, WIDTH=4, down-count from clear -> q 0,9,8,...,1,0,9; terminal_count=1 while q=0; enable=0 for 3 edges holds the value.
- MODULUS=10: load=1, load_value=7 -> q=7, load_error=0. Then load_value=12 -> q=0, load_error=1 for exactly one cycle, then 0.
- Simultaneous clear=1, load=1, enable=1 at q=5 -> q=RESET_VALUE (0). The next edge with load_value=4, enable=1 -> q=4 (load beats enable).
- Cascade two MODULUS=10 instances, the second enabled by the first's terminal_count, for 25 edges up -> {tens,units} = 2,5. The tens stage advances exactly on units 9->0.
- MODULUS=16, WIDTH=4, up from 14 -> 15, 0, 1. Reverse direction at q=1 -> 0, 15.
